// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer: XLEN, pcSrc, entry and slot
// bundles, counter reset value and the even-address mask.
package branch_target_buffer_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PCp4_I,
    Jump_R,
    Branch_C,
    Trap_C
  } pcSrc;

  localparam logic [1:0] BTB_CTR_RESET = 2'b01;

  localparam logic [XLEN-1:0] EVEN_MASK = ~XLEN'(1);

  // tag is stored right-justified (PC >> (IDX+2))
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } btbEntry;

  typedef struct packed {
    logic            v;
    logic [XLEN-1:0] pc;
    logic            pred;
    logic [XLEN-1:0] tgt;
  } btbSlot;

endpackage

// File: rtl/branch_target_buffer_counter.sv
// 2-bit saturating direction counter update.
// Ports: ctr (current), taken (direction), ctr_next (updated value).
module branch_target_buffer_counter (
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    unique case (1'b1)
      (taken && ctr != 2'b11):  ctr_next = ctr + 2'd1;
      (!taken && ctr != 2'b00): ctr_next = ctr - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: I-stage lookup, I->R->C prediction slots, C training.
// Ports: clk/reset, PC_I->Predict/Prediction, stalls/flushes, R/C resolve.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC_I,
  output logic            Predict,
  output logic [XLEN-1:0] Prediction,
  input  logic            StallI,
  input  logic            StallR,
  input  logic            FlushIR,
  input  logic            FlushRC,
  input  pcSrc            PCSrc_R,
  input  logic [XLEN-1:0] PCpImm_R,
  input  logic            IsControl_C,
  input  logic            IsJump_C,
  input  logic            Taken_C,
  input  logic [XLEN-1:0] Target_C,
  output logic            PredictionCorrect_R,
  output logic            PredictionCorrect_C
);

  localparam int IDX = $clog2(ENTRIES);

  btbEntry entries_q [ENTRIES];
  btbEntry entries_d [ENTRIES];
  btbSlot  r_q, r_d;
  btbSlot  c_q, c_d;

  logic [IDX-1:0] idx_i;
  btbEntry        ent_i;
  logic           hit_i;

  assign idx_i = PC_I[IDX+1:2];
  assign ent_i = entries_q[idx_i];
  assign hit_i = ent_i.valid && (ent_i.tag == (PC_I >> (IDX+2)));

  assign Predict    = hit_i && ent_i.ctr[1];
  assign Prediction = hit_i ? (ent_i.target & EVEN_MASK) : '0;

  logic [IDX-1:0] idx_c;
  btbEntry        ent_c;
  logic           hit_c;
  logic           train;
  logic [1:0]     ctr_next;

  assign idx_c = c_q.pc[IDX+1:2];
  assign ent_c = entries_q[idx_c];
  assign hit_c = ent_c.valid && (ent_c.tag == (c_q.pc >> (IDX+2)));
  assign train = c_q.v && IsControl_C && !StallR;

  branch_target_buffer_counter u_ctr (
    .ctr      (ent_c.ctr),
    .taken    (Taken_C),
    .ctr_next (ctr_next)
  );

  always_comb begin
    entries_d = entries_q;
    if (train) begin
      unique case (1'b1)
        (hit_c && IsJump_C): begin
          entries_d[idx_c].ctr    = 2'b11;
          entries_d[idx_c].target = Target_C;
        end
        (hit_c && !IsJump_C): begin
          entries_d[idx_c].ctr = ctr_next;
          if (Taken_C) entries_d[idx_c].target = Target_C;
        end
        (!hit_c && Taken_C): begin
          entries_d[idx_c].valid  = 1'b1;
          entries_d[idx_c].tag    = c_q.pc >> (IDX+2);
          entries_d[idx_c].target = Target_C;
          entries_d[idx_c].ctr    = IsJump_C ? 2'b11 : 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    r_d = r_q;
    if (FlushIR) r_d.v = 1'b0;
    else if (!StallI)
      r_d = '{v: 1'b1, pc: PC_I, pred: Predict, tgt: Prediction};
  end

  // A stalled R instruction stays put, so C gets a bubble instead of
  // a duplicate -- unless R is being flushed and may move on.
  always_comb begin
    c_d = c_q;
    if (FlushRC) c_d.v = 1'b0;
    else if (!StallR) begin
      if (StallI && !FlushIR) c_d.v = 1'b0;
      else c_d = r_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                          ctr: BTB_CTR_RESET};
      r_q <= '0;
      c_q <= '0;
    end else begin
      entries_q <= entries_d;
      r_q       <= r_d;
      c_q       <= c_d;
    end
  end

  assign PredictionCorrect_R = r_q.v && r_q.pred && (PCSrc_R == Jump_R) &&
                               (r_q.tgt == (PCpImm_R & EVEN_MASK));

  assign PredictionCorrect_C = c_q.v && IsControl_C && (c_q.pred == Taken_C) &&
                               (!Taken_C || (c_q.tgt == (Target_C & EVEN_MASK)));

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios then random traffic
// against an arithmetic reference model.
module tb_branch_target_buffer;
  import branch_target_buffer_pkg::*;

  localparam int N = 16;
  localparam logic [31:0] FILL = 32'h0000_0ff4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_I;
  logic        Predict;
  logic [31:0] Prediction;
  logic        StallI, StallR, FlushIR, FlushRC;
  pcSrc        PCSrc_R;
  logic [31:0] PCpImm_R;
  logic        IsControl_C, IsJump_C, Taken_C;
  logic [31:0] Target_C;
  logic        PredictionCorrect_R, PredictionCorrect_C;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_target_buffer #(.ENTRIES(N)) dut (
    .clk(clk), .reset(reset), .PC_I(PC_I),
    .Predict(Predict), .Prediction(Prediction),
    .StallI(StallI), .StallR(StallR),
    .FlushIR(FlushIR), .FlushRC(FlushRC),
    .PCSrc_R(PCSrc_R), .PCpImm_R(PCpImm_R),
    .IsControl_C(IsControl_C), .IsJump_C(IsJump_C),
    .Taken_C(Taken_C), .Target_C(Target_C),
    .PredictionCorrect_R(PredictionCorrect_R),
    .PredictionCorrect_C(PredictionCorrect_C)
  );

  bit          m_valid [N];
  int unsigned m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  bit          r_v, r_pred, c_v, c_pred;
  logic [31:0] r_pc, r_tgt, c_pc, c_tgt;

  function automatic int unsigned midx(logic [31:0] pc);
    return (pc / 4) % N;
  endfunction

  function automatic int unsigned mtag(logic [31:0] pc);
    return pc / (4 * N);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[midx(pc)] && m_tag[midx(pc)] == mtag(pc);
  endfunction

  function automatic bit e_predict(logic [31:0] pc);
    return m_hit(pc) && m_ctr[midx(pc)] >= 2;
  endfunction

  function automatic logic [31:0] e_prediction(logic [31:0] pc);
    return m_hit(pc) ? (m_tgt[midx(pc)] & 32'hFFFF_FFFE) : 32'h0;
  endfunction

  function automatic bit e_pcr_r();
    return r_v && r_pred && PCSrc_R == Jump_R &&
           r_tgt == (PCpImm_R & 32'hFFFF_FFFE);
  endfunction

  function automatic bit e_pcr_c();
    return c_v && IsControl_C && (c_pred == Taken_C) &&
           (!Taken_C || c_tgt == (Target_C & 32'hFFFF_FFFE));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    r_v = 0; r_pred = 0; r_pc = 0; r_tgt = 0;
    c_v = 0; c_pred = 0; c_pc = 0; c_tgt = 0;
  endtask

  task automatic model_edge();
    bit np;
    logic [31:0] nt;
    int unsigned i;
    np = e_predict(PC_I);
    nt = e_prediction(PC_I);
    if (c_v && IsControl_C && !StallR) begin
      i = midx(c_pc);
      if (m_hit(c_pc)) begin
        if (IsJump_C) begin
          m_ctr[i] = 3; m_tgt[i] = Target_C;
        end else if (Taken_C) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = Target_C;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (Taken_C) begin
        m_valid[i] = 1; m_tag[i] = mtag(c_pc); m_tgt[i] = Target_C;
        m_ctr[i] = IsJump_C ? 3 : 2;
      end
    end
    if (FlushRC) c_v = 0;
    else if (!StallR) begin
      if (StallI && !FlushIR) c_v = 0;
      else begin
        c_v = r_v; c_pc = r_pc; c_pred = r_pred; c_tgt = r_tgt;
      end
    end
    if (FlushIR) r_v = 0;
    else if (!StallI) begin
      r_v = 1; r_pc = PC_I; r_pred = np; r_tgt = nt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("predict", Predict, e_predict(PC_I));
    chk("prediction", Prediction, e_prediction(PC_I));
    chk("correct_r", PredictionCorrect_R, e_pcr_r());
    chk("correct_c", PredictionCorrect_C, e_pcr_c());
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  task automatic idle();
    StallI = 0; StallR = 0; FlushIR = 0; FlushRC = 0;
    PCSrc_R = PCp4_I; PCpImm_R = 0;
    IsControl_C = 0; IsJump_C = 0; Taken_C = 0; Target_C = 0;
  endtask

  task automatic resolve(input logic [31:0] pc, input bit jmp,
                         input bit tk, input logic [31:0] tgt);
    idle(); PC_I = pc; tick();
    PC_I = FILL; tick();
    IsControl_C = 1; IsJump_C = jmp; Taken_C = tk; Target_C = tgt;
    tick();
    idle();
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input bit ep, input logic [31:0] et);
    idle(); PC_I = pc; #1;
    chk({tag, "_p"}, Predict, ep);
    chk({tag, "_t"}, Prediction, et);
    tick();
  endtask

  initial begin
    reset = 1; idle(); PC_I = 0; model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    PC_I = 32'h100; #1;
    chk("rst_pred", Predict, 0);
    chk("rst_tgt", Prediction, 0);
    chk("rst_cr", PredictionCorrect_R, 0);
    chk("rst_cc", PredictionCorrect_C, 0);
    tick();

    resolve(32'h100, 0, 1, 32'h80);
    lookup("alloc", 32'h100, 1, 32'h80);

    resolve(32'h100, 0, 0, 0);
    resolve(32'h100, 0, 0, 0);
    lookup("decay00", 32'h100, 0, 32'h80);
    resolve(32'h100, 0, 1, 32'h80);
    lookup("decay01", 32'h100, 0, 32'h80);

    lookup("alias_miss", 32'h140, 0, 0);
    resolve(32'h140, 0, 1, 32'h200);
    lookup("alias_new", 32'h140, 1, 32'h200);
    lookup("alias_old", 32'h100, 0, 0);

    resolve(32'h140, 0, 0, 0);
    resolve(32'h140, 0, 0, 0);
    idle(); PC_I = 32'h140; tick();
    PC_I = FILL; tick();
    IsControl_C = 1; Taken_C = 1; Target_C = 32'h200;
    StallI = 1; StallR = 1;
    repeat (3) tick();
    StallI = 0; StallR = 0; tick();
    lookup("stall_once", 32'h140, 0, 32'h200);
    resolve(32'h140, 0, 1, 32'h200);
    lookup("stall_next", 32'h140, 1, 32'h200);

    resolve(32'h40, 1, 1, 32'h301);
    lookup("jmp_look", 32'h40, 1, 32'h300);
    PC_I = FILL; PCSrc_R = Jump_R; PCpImm_R = 32'h301; #1;
    chk("jmp_r", PredictionCorrect_R, 1);
    tick();
    idle(); PC_I = 32'h40; FlushIR = 1; tick();
    FlushIR = 0; PC_I = FILL; PCSrc_R = Jump_R; PCpImm_R = 32'h301; #1;
    chk("jmp_r_flush", PredictionCorrect_R, 0);
    tick();

    idle(); PC_I = 32'h40; #1;
    chk("pre_rst_pred", Predict, 1);
    #1 reset = 1; #1;
    chk("mid_rst_pred", Predict, 0);
    chk("mid_rst_tgt", Prediction, 0);
    chk("mid_rst_cr", PredictionCorrect_R, 0);
    chk("mid_rst_cc", PredictionCorrect_C, 0);
    model_reset();
    @(posedge clk); #1 reset = 0;
    lookup("post_rst", 32'h40, 0, 0);

    repeat (400) begin
      PC_I = (32'($urandom_range(0, 31)) << 2) +
             ($urandom_range(0, 1) ? 32'h1000 : 32'h0);
      StallI  = ($urandom_range(0, 7) == 0);
      StallR  = ($urandom_range(0, 7) == 0);
      FlushIR = ($urandom_range(0, 7) == 0);
      FlushRC = ($urandom_range(0, 7) == 0);
      PCSrc_R = pcSrc'($urandom_range(0, 3));
      PCpImm_R = $urandom_range(0, 1) ? (r_tgt | 32'($urandom_range(0, 1)))
                                      : 32'($urandom_range(0, 1023));
      IsControl_C = $urandom_range(0, 1);
      IsJump_C = ($urandom_range(0, 3) == 0);
      Taken_C = IsJump_C ? 1'b1 :
                ($urandom_range(0, 1) ? c_pred : 1'($urandom_range(0, 1)));
      Target_C = $urandom_range(0, 1) ? (c_tgt | 32'($urandom_range(0, 1)))
                                      : 32'($urandom_range(0, 1023));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
